systolic_tile_drain: RTL

Downstream output stage of the 4x4 systolic matrix-multiply tile.
- Captures the full ROWS x COLS INT32 accumulator tile on the array's one-cycle done pulse.
- Requantizes each element to INT8: per-column bias add, rounding arithmetic right shift, saturation.
- Streams the result one row per beat over a valid/ready interface toward the output buffer/writeback.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/requant_lane.sv | 50 +++++
 rtl/systolic_tile_drain.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic tile drain stage.
// Build option: SYSTOLIC_DRAIN_RELU_EN enables ReLU clamping after saturation.
package systolic_pkg;

    localparam int DEF_ACCW = 32;
    localparam int DEF_OW   = 8;
    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
    localparam int DEF_SHW  = 5;

    typedef logic signed [DEF_ACCW-1:0] acc_t;
    typedef logic signed [DEF_OW-1:0]   out_t;
    typedef out_t [DEF_COLS-1:0]        out_row_t;

    typedef enum logic {
        IDLE,
        DRAIN
    } drain_state_e;

endpackage

// File: rtl/requant_lane.sv
// One column lane: bias add, round-half-up shift, saturate, optional ReLU.
// Build option: SYSTOLIC_DRAIN_RELU_EN forces negative results to zero.
module requant_lane
    import systolic_pkg::*;
#(
    parameter int ACCW = DEF_ACCW,
    parameter int OW   = DEF_OW,
    parameter int SHW  = DEF_SHW
) (
    input  logic signed [ACCW-1:0] acc_i,
    input  logic signed [ACCW-1:0] bias_i,
    input  logic        [SHW-1:0]  shift_i,
    output logic signed [OW-1:0]   q_o,
    output logic                   clip_o
);

    // Two guard bits: one for the bias add, one for the rounding increment.
    localparam int SW = ACCW + 2;
    localparam logic signed [SW-1:0] MAXV = SW'((1 << (OW - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] rnd;
    logic signed [SW-1:0] shr;

    always_comb begin
        sum = {{2{acc_i[ACCW-1]}}, acc_i} + {{2{bias_i[ACCW-1]}}, bias_i};
        rnd = sum;
        if (shift_i != '0) begin
            rnd = sum + (SW'(1) << (shift_i - 1'b1));
        end
        shr = rnd >>> shift_i;
        clip_o = 1'b0;
        q_o = shr[OW-1:0];
        if (shr > MAXV) begin
            q_o = MAXV[OW-1:0];
            clip_o = 1'b1;
        end else if (shr < MINV) begin
            q_o = MINV[OW-1:0];
            clip_o = 1'b1;
        end
`ifdef SYSTOLIC_DRAIN_RELU_EN
        if (q_o[OW-1]) begin
            q_o = '0;
        end
`else
`endif
    end

endmodule

// File: rtl/systolic_tile_drain.sv
// Captures a finished accumulator tile and streams requantized INT8 rows.
// Build option: SYSTOLIC_DRAIN_RELU_EN selects ReLU output range in the lanes.
module systolic_tile_drain
    import systolic_pkg::*;
#(
    parameter int ACCW = DEF_ACCW,
    parameter int OW   = DEF_OW,
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int SHW  = DEF_SHW,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    tile_valid,
    input  logic signed [ROWS-1:0][COLS-1:0][ACCW-1:0] C_in,
    input  logic signed [COLS-1:0][ACCW-1:0]         bias,
    input  logic        [SHW-1:0]                    shift,
    output logic                                    tile_ready,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic signed [COLS-1:0][OW-1:0]           out_data,
    output logic        [RW-1:0]                     out_row,
    output logic                                    out_last,
    output logic                                    tile_dropped,
    output logic        [15:0]                       sat_cnt
);

    drain_state_e state_q;

    logic signed [ROWS-1:0][COLS-1:0][ACCW-1:0] buf_q;
    logic signed [COLS-1:0][ACCW-1:0]           bias_q;
    logic        [SHW-1:0]                      shift_q;
    logic signed [COLS-1:0][OW-1:0]             data_q;
    logic        [COLS-1:0]                     clip_q;
    logic        [RW-1:0]                       row_q;
    logic                                       valid_q;
    logic                                       ready_q;
    logic                                       dropped_q;
    logic        [15:0]                         sat_q;
    logic        [15:0]                         sat_d;

    logic signed [COLS-1:0][ACCW-1:0] lane_acc;
    logic signed [COLS-1:0][ACCW-1:0] lane_bias;
    logic        [SHW-1:0]            lane_sh;
    logic signed [COLS-1:0][OW-1:0]   lane_q;
    logic        [COLS-1:0]           lane_clip;
    logic        [RW-1:0]             row_nxt;
    logic        [16:0]               sat_sum;

    // Idle lanes see the incoming tile's row 0 so it is ready on the next cycle;
    // in DRAIN they precompute the following row from the captured buffer.
    always_comb begin
        row_nxt = row_q + 1'b1;
        lane_acc = C_in[0];
        lane_bias = bias;
        lane_sh = shift;
        if (state_q == DRAIN) begin
            lane_acc = buf_q[row_nxt];
            lane_bias = bias_q;
            lane_sh = shift_q;
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        requant_lane #(
            .ACCW (ACCW),
            .OW   (OW),
            .SHW  (SHW)
        ) u_lane (
            .acc_i  (lane_acc[c]),
            .bias_i (lane_bias[c]),
            .shift_i(lane_sh),
            .q_o    (lane_q[c]),
            .clip_o (lane_clip[c])
        );
    end

    always_comb begin
        sat_sum = {1'b0, sat_q};
        for (int c = 0; c < COLS; c++) begin
            sat_sum = sat_sum + 17'(clip_q[c]);
        end
        sat_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            data_q    <= '0;
            clip_q    <= '0;
            row_q     <= '0;
            dropped_q <= 1'b0;
            sat_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tile_valid) begin
                        buf_q   <= C_in;
                        bias_q  <= bias;
                        shift_q <= shift;
                        state_q <= DRAIN;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                        row_q   <= '0;
                        data_q  <= lane_q;
                        clip_q  <= lane_clip;
                    end
                end
                DRAIN: begin
                    if (tile_valid) begin
                        dropped_q <= 1'b1;
                    end
                    if (out_ready) begin
                        sat_q <= sat_d;
                        if (row_q == RW'(ROWS - 1)) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                            row_q   <= '0;
                            data_q  <= '0;
                            clip_q  <= '0;
                        end else begin
                            row_q  <= row_nxt;
                            data_q <= lane_q;
                            clip_q <= lane_clip;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tile_ready   = ready_q;
    assign out_valid    = valid_q;
    assign out_data     = data_q;
    assign out_row      = row_q;
    assign out_last     = valid_q && (row_q == RW'(ROWS - 1));
    assign tile_dropped = dropped_q;
    assign sat_cnt      = sat_q;

endmodule
